lsu_axi_master: RTL and testbench

LSU_AXI_MASTER -- requirements
Module: lsu_axi_master

---
 rtl/lsu_axi_master.sv | 186 ++++++++++++++++++
 tb/tb_lsu_axi_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axi_master.sv
// LSU bus master: one load/store at a time over split AXI-style channels.
// Loads are lane-extracted and extended; stores are lane-shifted with strobes.
module lsu_axi_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [31:0] wdata,
  output logic        awvalid,
  output logic        wvalid,
  input  logic        awready,
  input  logic        wready,
  output logic [7:0]  wstrb,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, ERR
  } state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_lane;
  logic [2:0]  r_size;
  logic        r_aw_done, r_w_done;
  logic        r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
  logic [31:0] r_araddr, r_awaddr, r_wdata;
  logic [7:0]  r_wstrb;
  logic        r_resp_valid, r_resp_err;
  logic [31:0] r_resp_rdata;

  logic        w_accept, w_bad, w_misal, w_legal;
  logic        w_aw_hs, w_w_hs, w_aw_fin, w_w_fin;
  logic [3:0]  w_mask, w_strb;
  logic [31:0] w_sh, w_ext;

  assign w_accept = req_valid && (r_state == IDLE);
  assign w_aw_hs  = r_awvalid && awready;
  assign w_w_hs   = r_wvalid && wready;
  assign w_aw_fin = r_aw_done || w_aw_hs;
  assign w_w_fin  = r_w_done || w_w_hs;

  always_comb begin
    w_misal = ((req_size[1:0] == 2'b01) && req_addr[0]) ||
              ((req_size == 3'b010) && (req_addr[1:0] != 2'b00));
    if (req_we)
      w_legal = req_size inside {3'b000, 3'b001, 3'b010};
    else
      w_legal = req_size inside {3'b000, 3'b001, 3'b010,
                                 3'b100, 3'b101};
    w_bad = w_misal || !w_legal;
  end

  always_comb begin
    unique case (req_size[1:0])
      2'b00:   w_mask = 4'b0001;
      2'b01:   w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
    w_strb = w_mask << req_addr[1:0];
  end

  // Extraction uses the latched lane/size, not the live request inputs.
  always_comb begin
    w_sh = rdata >> {r_lane, 3'b000};
    unique case (r_size)
      3'b000:  w_ext = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b001:  w_ext = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b100:  w_ext = {24'h0, w_sh[7:0]};
      3'b101:  w_ext = {16'h0, w_sh[15:0]};
      default: w_ext = w_sh;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (req_valid) begin
          if (w_bad)       w_next = ERR;
          else if (req_we) w_next = WR_REQ;
          else             w_next = RD_ADDR;
        end
      RD_ADDR: if (r_arvalid && arready) w_next = RD_DATA;
      RD_DATA: if (rvalid) w_next = IDLE;
      WR_REQ:  if (w_aw_fin && w_w_fin) w_next = WR_RESP;
      WR_RESP: if (bvalid) w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_lane       <= 2'b00;
      r_size       <= 3'b000;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_araddr     <= 32'h0;
      r_awaddr     <= 32'h0;
      r_wdata      <= 32'h0;
      r_wstrb      <= 8'h0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
    end else begin
      r_state   <= w_next;
      r_arvalid <= (w_next == RD_ADDR);
      r_rready  <= (w_next == RD_DATA);
      r_bready  <= (w_next == WR_RESP);
      r_awvalid <= (w_next == WR_REQ) && !w_aw_fin;
      r_wvalid  <= (w_next == WR_REQ) && !w_w_fin;
      if (r_state == WR_REQ) begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end else begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_accept) begin
        r_lane   <= req_addr[1:0];
        r_size   <= req_size;
        r_araddr <= {req_addr[31:2], 2'b00};
        r_awaddr <= {req_addr[31:2], 2'b00};
        r_wdata  <= req_wdata << {req_addr[1:0], 3'b000};
        r_wstrb  <= {4'h0, w_strb};
      end
      r_resp_valid <= 1'b0;
      unique case (1'b1)
        (r_state == ERR): begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
          r_resp_rdata <= 32'h0;
        end
        (r_state == RD_DATA) && rvalid: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= rresp;
          r_resp_rdata <= rresp ? 32'h0 : w_ext;
        end
        (r_state == WR_RESP) && bvalid: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= |bresp;
          r_resp_rdata <= 32'h0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign araddr     = r_araddr;
  assign arvalid    = r_arvalid;
  assign rready     = r_rready;
  assign awaddr     = r_awaddr;
  assign wdata      = r_wdata;
  assign awvalid    = r_awvalid;
  assign wvalid     = r_wvalid;
  assign wstrb      = r_wstrb;
  assign bready     = r_bready;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: loads, stores, errors, stalls, reset.
// Inputs driven and outputs sampled on the falling edge.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic        rresp, rvalid, rready;
  logic [31:0] awaddr, wdata;
  logic        awvalid, wvalid, awready, wready;
  logic [7:0]  wstrb;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_axi_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .rready(rready),
    .awaddr(awaddr), .wdata(wdata),
    .awvalid(awvalid), .wvalid(wvalid),
    .awready(awready), .wready(wready),
    .wstrb(wstrb), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send(input logic we, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    check("idle_rdy", {31'b0, req_ready}, 32'd1);
    check("no_resp", {31'b0, resp_valid}, 32'd0);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic scramble();
    req_valid = 1'b0;
    req_we    = ~req_we;
    req_size  = 3'b111;
    req_addr  = 32'h0;
    req_wdata = 32'hFFFF_FFFF;
  endtask

  task automatic do_load(input string tag, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] rd,
                         input logic rr, input logic [31:0] exp_ar,
                         input logic [31:0] exp_d, input logic exp_e);
    send(1'b0, sz, a, 32'h0);
    @(negedge clk);
    scramble();
    check({tag, "_arv"}, {31'b0, arvalid}, 32'd1);
    check({tag, "_ara"}, araddr, exp_ar);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check({tag, "_arv0"}, {31'b0, arvalid}, 32'd0);
    check({tag, "_rrdy"}, {31'b0, rready}, 32'd1);
    rvalid = 1'b1;
    rdata  = rd;
    rresp  = rr;
    @(negedge clk);
    rvalid = 1'b0;
    rdata  = 32'h5A5A_5A5A;
    check({tag, "_rv"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_rd"}, resp_rdata, exp_d);
    check({tag, "_re"}, {31'b0, resp_err}, {31'b0, exp_e});
    check({tag, "_rrdy0"}, {31'b0, rready}, 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] br,
                          input logic [31:0] exp_aw,
                          input logic [31:0] exp_wd,
                          input logic [7:0] exp_st,
                          input logic exp_e);
    send(1'b1, sz, a, d);
    @(negedge clk);
    scramble();
    check({tag, "_awv"}, {31'b0, awvalid}, 32'd1);
    check({tag, "_wv"}, {31'b0, wvalid}, 32'd1);
    check({tag, "_awa"}, awaddr, exp_aw);
    check({tag, "_wd"}, wdata, exp_wd);
    check({tag, "_st"}, {24'b0, wstrb}, {24'b0, exp_st});
    awready = 1'b1;
    wready  = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    wready  = 1'b0;
    check({tag, "_awv0"}, {31'b0, awvalid}, 32'd0);
    check({tag, "_wv0"}, {31'b0, wvalid}, 32'd0);
    check({tag, "_brdy"}, {31'b0, bready}, 32'd1);
    bvalid = 1'b1;
    bresp  = br;
    @(negedge clk);
    bvalid = 1'b0;
    bresp  = 2'b00;
    check({tag, "_rv"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_re"}, {31'b0, resp_err}, {31'b0, exp_e});
    check({tag, "_rd"}, resp_rdata, 32'h0);
  endtask

  task automatic do_err(input string tag, input logic we,
                        input logic [2:0] sz, input logic [31:0] a);
    send(we, sz, a, 32'h1234_5678);
    @(negedge clk);
    scramble();
    check({tag, "_bus"}, {29'b0, arvalid, awvalid, wvalid}, 32'd0);
    check({tag, "_rv0"}, {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_rv"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_re"}, {31'b0, resp_err}, 32'd1);
    check({tag, "_rd"}, resp_rdata, 32'h0);
    check({tag, "_bus2"}, {29'b0, arvalid, awvalid, wvalid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    arready = 1'b0; rdata = 32'h0; rresp = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("rst_rdy", {31'b0, req_ready}, 32'd1);
    check("rst_vld", {26'b0, resp_valid, arvalid, rready,
                      awvalid, wvalid, bready}, 32'd0);
    check("rst_misc", {24'b0, wstrb} | araddr | awaddr | wdata |
                      resp_rdata | {31'b0, resp_err}, 32'h0);
    rst = 1'b0;

    do_load("lw", 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0,
            32'h8000_0004, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check("hold_rv", {31'b0, resp_valid}, 32'd0);
    check("hold_rd", resp_rdata, 32'hDEAD_BEEF);

    do_load("lb", 3'b000, 32'h8000_0003, 32'h8011_2233, 1'b0,
            32'h8000_0000, 32'hFFFF_FF80, 1'b0);
    do_load("lbu", 3'b100, 32'h8000_0003, 32'h8011_2233, 1'b0,
            32'h8000_0000, 32'h0000_0080, 1'b0);
    do_load("lh", 3'b001, 32'h8000_0002, 32'h8001_7FFF, 1'b0,
            32'h8000_0000, 32'hFFFF_8001, 1'b0);
    do_load("lhu", 3'b101, 32'h8000_0002, 32'h8001_7FFF, 1'b0,
            32'h8000_0000, 32'h0000_8001, 1'b0);
    do_load("lb1", 3'b000, 32'h8000_0001, 32'h1122_7F44, 1'b0,
            32'h8000_0000, 32'h0000_007F, 1'b0);
    do_load("lwerr", 3'b010, 32'h8000_0010, 32'h1234_5678, 1'b1,
            32'h8000_0010, 32'h0000_0000, 1'b1);

    do_store("sh", 3'b001, 32'h8000_0002, 32'h0000_ABCD, 2'b00,
             32'h8000_0000, 32'hABCD_0000, 8'h0C, 1'b0);
    do_store("sb", 3'b000, 32'h8000_0001, 32'h0000_00EE, 2'b00,
             32'h8000_0000, 32'h0000_EE00, 8'h02, 1'b0);
    do_store("sw", 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 2'b10,
             32'h8000_0008, 32'hCAFE_F00D, 8'h0F, 1'b1);

    do_err("lwmis", 1'b0, 3'b010, 32'h8000_0002);
    do_err("lhmis", 1'b0, 3'b001, 32'h8000_0001);
    do_err("ldsz", 1'b0, 3'b011, 32'h8000_0000);
    do_err("sbusz", 1'b1, 3'b100, 32'h8000_0000);

    // AW accepted two cycles ahead of W, then one B wait state.
    send(1'b1, 3'b010, 32'h8000_0010, 32'h1234_5678);
    @(negedge clk);
    scramble();
    check("st_awv", {31'b0, awvalid}, 32'd1);
    check("st_wv", {31'b0, wvalid}, 32'd1);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    check("st_awdrop", {31'b0, awvalid}, 32'd0);
    check("st_whold", {31'b0, wvalid}, 32'd1);
    check("st_nob", {31'b0, bready}, 32'd0);
    @(negedge clk);
    check("st_whold2", {31'b0, wvalid}, 32'd1);
    check("st_awlow", {31'b0, awvalid}, 32'd0);
    wready = 1'b1;
    @(negedge clk);
    wready = 1'b0;
    check("st_wdrop", {31'b0, wvalid}, 32'd0);
    check("st_brdy", {31'b0, bready}, 32'd1);
    @(negedge clk);
    check("st_bwait", {31'b0, bready}, 32'd1);
    check("st_nrv", {31'b0, resp_valid}, 32'd0);
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    check("st_rv", {31'b0, resp_valid}, 32'd1);
    check("st_re", {31'b0, resp_err}, 32'd0);
    @(negedge clk);
    check("st_pulse", {31'b0, resp_valid}, 32'd0);

    // Stray R/B beats in IDLE must not produce a response.
    rvalid = 1'b1;
    bvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    bvalid = 1'b0;
    check("stray_rv", {31'b0, resp_valid}, 32'd0);
    check("stray_rdy", {31'b0, req_ready}, 32'd1);

    // Reset while waiting for read data.
    send(1'b0, 3'b010, 32'h8000_0020, 32'h0);
    @(negedge clk);
    scramble();
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("mr_rrdy", {31'b0, rready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_rrdy0", {31'b0, rready}, 32'd0);
    check("mr_rdy", {31'b0, req_ready}, 32'd1);
    check("mr_rv", {31'b0, resp_valid}, 32'd0);
    rvalid = 1'b1;
    rdata  = 32'h0BAD_0BAD;
    @(negedge clk);
    rvalid = 1'b0;
    check("mr_rv2", {31'b0, resp_valid}, 32'd0);
    check("mr_rd", resp_rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
